// File: rtl/lsu_req.sv
// lsu_req: load/store request stage; decodes DTCM/ITCM target, issues one aligned TCM request,
// returns a one-cycle result pulse to lsu_wb. ITCM routing enabled by ZCRV_LSU_ITCM_ACCESS_EN.
module lsu_req #(
    parameter logic [31:0] ITCM_BASE = 32'h8000_0000,
    parameter int          REGION_AW = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid_from_ex,
    output logic        ls_ready_to_ex,
    input  logic [31:0] ls_addr_from_ex,
    input  logic [31:0] ls_wdata_from_ex,
    input  logic        rden_from_ex,
    input  logic [4:0]  load_info_from_ex,
    input  logic [2:0]  store_info_from_ex,
    input  logic [4:0]  rd_index_from_ex,
    input  logic        flush_from_eiu,
    output logic        dtcm_req_valid,
    input  logic        dtcm_req_ready,
    output logic [31:0] dtcm_addr,
    output logic        dtcm_wen,
    output logic [3:0]  dtcm_wmask,
    output logic [31:0] dtcm_wdata,
    input  logic        dtcm_rsp_valid,
    input  logic [31:0] dtcm_rsp_data,
    output logic        itcm_req_valid,
    input  logic        itcm_req_ready,
    output logic [31:0] itcm_addr,
    output logic        itcm_wen,
    output logic [3:0]  itcm_wmask,
    output logic [31:0] itcm_wdata,
    input  logic        itcm_rsp_valid,
    input  logic [31:0] itcm_rsp_data,
    output logic        ls_to_wb,
    output logic        ls_addr_error_to_wb,
    output logic        rden_to_wb,
    output logic [4:0]  load_info_to_wb,
    output logic [4:0]  rd_index_to_wb,
    output logic        res_from_dtcm_to_wb,
    output logic        res_from_itcm_to_wb,
    output logic [31:0] data_from_dtcm_to_wb,
    output logic [31:0] data_from_itcm_to_wb
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    state_t      r_state, w_next;
    logic        r_itcm, r_err, r_drop, r_rden;
    logic [1:0]  r_off;
    logic [29:0] r_word;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata, r_data;
    logic [4:0]  r_load_info, r_rd;
    logic        w_accept, w_misal, w_hit_itcm, w_req_ready, w_rsp_valid;
    logic        w_dsel, w_pulse, w_res;
    logic [31:0] w_rsp_data;
    logic [3:0]  w_wmask;
    logic [4:0]  w_sh_in;

    assign ls_ready_to_ex = r_state == S_IDLE;
    assign w_accept = ls_valid_from_ex & ls_ready_to_ex & ~flush_from_eiu;
    assign w_sh_in  = {ls_addr_from_ex[1:0], 3'b000};
    assign w_misal  = rden_from_ex
        ? ((load_info_from_ex[3] | load_info_from_ex[0]) & ls_addr_from_ex[0]) | (load_info_from_ex[2] & |ls_addr_from_ex[1:0])
        : (store_info_from_ex[1] & ls_addr_from_ex[0]) | (store_info_from_ex[0] & |ls_addr_from_ex[1:0]);
    assign w_wmask  = rden_from_ex          ? 4'b0000 :
                      store_info_from_ex[2] ? 4'b0001 << ls_addr_from_ex[1:0] :
                      store_info_from_ex[1] ? 4'b0011 << ls_addr_from_ex[1:0] :
                      store_info_from_ex[0] ? 4'b1111 : 4'b0000;

`ifdef ZCRV_LSU_ITCM_ACCESS_EN
    logic w_isel;
    assign w_hit_itcm     = ls_addr_from_ex[31:REGION_AW] == ITCM_BASE[31:REGION_AW];
    assign w_req_ready    = r_itcm ? itcm_req_ready : dtcm_req_ready;
    assign w_rsp_valid    = r_itcm ? itcm_rsp_valid : dtcm_rsp_valid;
    assign w_rsp_data     = r_itcm ? itcm_rsp_data : dtcm_rsp_data;
    assign w_isel         = (r_state == S_REQ) & r_itcm;
    assign itcm_req_valid = w_isel & ~flush_from_eiu;
    assign itcm_addr      = w_isel ? {r_word, 2'b00} : 32'd0;
    assign itcm_wen       = w_isel & ~r_rden;
    assign itcm_wmask     = w_isel ? r_wmask : 4'd0;
    assign itcm_wdata     = w_isel ? r_wdata : 32'd0;
    assign res_from_itcm_to_wb  = w_res & r_itcm;
    assign data_from_itcm_to_wb = (w_res & r_itcm) ? r_data : 32'd0;
`else
    logic w_unused_itcm;
    assign w_unused_itcm  = ^{itcm_req_ready, itcm_rsp_valid, itcm_rsp_data, ITCM_BASE, REGION_AW > 0};
    assign w_hit_itcm     = 1'b0;
    assign w_req_ready    = dtcm_req_ready;
    assign w_rsp_valid    = dtcm_rsp_valid;
    assign w_rsp_data     = dtcm_rsp_data;
    assign itcm_req_valid = 1'b0;
    assign itcm_addr      = 32'd0;
    assign itcm_wen       = 1'b0;
    assign itcm_wmask     = 4'd0;
    assign itcm_wdata     = 32'd0;
    assign res_from_itcm_to_wb  = 1'b0;
    assign data_from_itcm_to_wb = 32'd0;
`endif

    // Request fields come straight from registers so they hold steady while waiting for ready.
    assign w_dsel         = (r_state == S_REQ) & ~r_itcm;
    assign dtcm_req_valid = w_dsel & ~flush_from_eiu;
    assign dtcm_addr      = w_dsel ? {r_word, 2'b00} : 32'd0;
    assign dtcm_wen       = w_dsel & ~r_rden;
    assign dtcm_wmask     = w_dsel ? r_wmask : 4'd0;
    assign dtcm_wdata     = w_dsel ? r_wdata : 32'd0;

    assign w_pulse             = (r_state == S_RESP) & ~r_drop & ~flush_from_eiu;
    assign w_res               = w_pulse & ~r_err;
    assign ls_to_wb            = w_pulse;
    assign ls_addr_error_to_wb = w_pulse & r_err;
    assign rden_to_wb          = w_pulse & r_rden;
    assign load_info_to_wb     = w_pulse ? r_load_info : 5'd0;
    assign rd_index_to_wb      = w_pulse ? r_rd : 5'd0;
    assign res_from_dtcm_to_wb  = w_res & ~r_itcm;
    assign data_from_dtcm_to_wb = (w_res & ~r_itcm) ? r_data : 32'd0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: misaligned ops skip the TCM; flush in REQ drops the request before handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_misal ? S_RESP : S_REQ) : S_IDLE;
            S_REQ:   w_next = flush_from_eiu ? S_IDLE : (w_req_ready ? S_WAIT : S_REQ);
            S_WAIT:  w_next = w_rsp_valid ? S_RESP : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    // Operation descriptor, pre-shifted request, captured response and drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_itcm      <= 1'b0;
            r_err       <= 1'b0;
            r_rden      <= 1'b0;
            r_off       <= 2'd0;
            r_word      <= 30'd0;
            r_wmask     <= 4'd0;
            r_wdata     <= 32'd0;
            r_load_info <= 5'd0;
            r_rd        <= 5'd0;
            r_data      <= 32'd0;
            r_drop      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_itcm      <= w_hit_itcm;
                r_err       <= w_misal;
                r_rden      <= rden_from_ex;
                r_off       <= ls_addr_from_ex[1:0];
                r_word      <= ls_addr_from_ex[31:2];
                r_wmask     <= w_wmask;
                r_wdata     <= ls_wdata_from_ex << w_sh_in;
                r_load_info <= load_info_from_ex;
                r_rd        <= rd_index_from_ex;
            end
            if (r_state == S_WAIT && w_rsp_valid) r_data <= w_rsp_data >> {r_off, 3'b000};
            r_drop <= (r_state == S_WAIT) & (r_drop | flush_from_eiu);
        end
    end
endmodule
